// File: rtl/maze_read_arbiter.sv
// maze_read_arbiter
// Shares the single synchronous read port of the maze wall memory between
// the VGA renderer (fixed priority, starvation-guarded) and five game
// clients (pacman + four ghosts, served round-robin). Every grant returns
// its 5-bit wall word exactly two cycles later.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   vga_req/vga_index        VGA lookup request (level) and maze index
//   vga_grant                VGA accepted this cycle (combinational)
//   vga_valid/vga_data       result pulse and held result for VGA
//   req[4:0]/index[54:0]     client requests (0 = pacman, 1..4 = ghosts),
//                            index of client c at index[11*c +: 11]
//   grant[4:0]               one-hot client accept (combinational)
//   rvalid[4:0]/rdata[24:0]  per-client result pulse, held result of
//                            client c at rdata[5*c +: 5]
//   mem_addr/mem_rd          wall memory read port (combinational)
//   mem_data                 wall memory output, one cycle after address
module maze_read_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int DEPTH        = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [10:0] vga_index,
  output logic        vga_grant,
  output logic        vga_valid,
  output logic [4:0]  vga_data,
  input  logic [4:0]  req,
  input  logic [54:0] index,
  output logic [4:0]  grant,
  output logic [4:0]  rvalid,
  output logic [24:0] rdata,
  output logic [10:0] mem_addr,
  output logic        mem_rd,
  input  logic [4:0]  mem_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [11:0]   DEPTH_W    = 12'(DEPTH);

  logic [SW-1:0] starve_q, starve_d;
  logic [2:0]    rr_q, rr_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_vga_q, s1_vga_d;
  logic [2:0]    s1_owner_q, s1_owner_d;
  logic          s1_oor_q, s1_oor_d;
  logic [4:0]    rvalid_q, rvalid_d;
  logic [24:0]   rdata_q, rdata_d;
  logic          vga_valid_q, vga_valid_d;
  logic [4:0]    vga_data_q, vga_data_d;

  logic          any_req, starved, vga_win, cli_win, found, any_gnt, oor;
  logic [2:0]    sel;
  logic [3:0]    cand;
  logic [10:0]   gnt_idx;
  logic [4:0]    result;

  // Arbitration and memory request
  always_comb begin
    any_req = |req;
    // VGA yields for one cycle once it has starved pending clients long enough
    starved = any_req && (starve_q == STARVE_MAX);
    vga_win = !rst && vga_req && !starved;

    found = 1'b0;
    sel   = 3'd0;
    cand  = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end
    end
    cli_win = !rst && !vga_win && found;

    vga_grant = vga_win;
    grant     = cli_win ? (5'b00001 << sel) : 5'b00000;
    any_gnt   = vga_win || cli_win;

    gnt_idx  = vga_win ? vga_index : index[int'(sel)*11 +: 11];
    oor      = ({1'b0, gnt_idx} >= DEPTH_W);
    mem_addr = any_gnt ? gnt_idx : 11'd0;
    mem_rd   = any_gnt && !oor;
  end

  // Starve counter, round-robin pointer and stage-1 tag
  always_comb begin
    starve_d = starve_q;
    if (vga_win && any_req) begin
      if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
    end else if (cli_win || !any_req) begin
      starve_d = '0;
    end

    rr_d = cli_win ? sel : rr_q;

    s1_valid_d = any_gnt;
    s1_vga_d   = vga_win;
    s1_owner_d = sel;
    s1_oor_d   = oor;
  end

  // Stage 2: route the memory word (or the all-walls word) to its owner
  always_comb begin
    result      = s1_oor_q ? 5'b11111 : mem_data;
    rvalid_d    = 5'b00000;
    rdata_d     = rdata_q;
    vga_valid_d = 1'b0;
    vga_data_d  = vga_data_q;
    if (s1_valid_q) begin
      if (s1_vga_q) begin
        vga_valid_d = 1'b1;
        vga_data_d  = result;
      end else begin
        rvalid_d[s1_owner_q]                 = 1'b1;
        rdata_d[int'(s1_owner_q)*5 +: 5]     = result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= '0;
      rr_q        <= 3'd4;
      s1_valid_q  <= 1'b0;
      s1_vga_q    <= 1'b0;
      s1_owner_q  <= 3'd0;
      s1_oor_q    <= 1'b0;
      rvalid_q    <= 5'b00000;
      rdata_q     <= 25'd0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= 5'd0;
    end else begin
      starve_q    <= starve_d;
      rr_q        <= rr_d;
      s1_valid_q  <= s1_valid_d;
      s1_vga_q    <= s1_vga_d;
      s1_owner_q  <= s1_owner_d;
      s1_oor_q    <= s1_oor_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign vga_valid = vga_valid_q;
  assign vga_data  = vga_data_q;

endmodule

// File: tb/tb_maze_read_arbiter.sv
module tb_maze_read_arbiter;

  localparam int LIMIT = 8;
  localparam int DEPTH = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [10:0] vga_index;
  logic        vga_grant;
  logic        vga_valid;
  logic [4:0]  vga_data;
  logic [4:0]  req;
  logic [54:0] index;
  logic [4:0]  grant;
  logic [4:0]  rvalid;
  logic [24:0] rdata;
  logic [10:0] mem_addr;
  logic        mem_rd;
  logic [4:0]  mem_data = 5'd0;

  int checks = 0;
  int errors = 0;

  logic [4:0] wall_mem [0:2047];

  maze_read_arbiter #(.STARVE_LIMIT(LIMIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_index(vga_index), .vga_grant(vga_grant),
    .vga_valid(vga_valid), .vga_data(vga_data),
    .req(req), .index(index), .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Synchronous wall memory
  always @(posedge clk) if (mem_rd) mem_data <= wall_mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_rr, m_starve, win, addr;
  logic [4:0] m_rdata [5];
  logic [4:0] m_vga;
  logic       p0_v, p1_v, p0_vga, p1_vga;
  int         p0_o, p1_o;
  logic [4:0] p0_d, p1_d;
  logic [4:0] e_rv, e_grant;
  logic       e_vv, e_rd, any;
  logic [24:0] e_rdata;
  logic [4:0] val;

  always @(negedge clk) begin
    if (rst) begin
      m_rr = 4; m_starve = 0; p0_v = 0; p1_v = 0; m_vga = 0;
      for (int c = 0; c < 5; c++) m_rdata[c] = 0;
      chk("reset_outputs", 64'({grant, vga_grant, mem_rd, mem_addr, rvalid,
                                vga_valid, rdata, vga_data}), 64'd0);
    end else begin
      // results of the grant made two cycles ago
      e_rv = 0; e_vv = 0;
      if (p1_v) begin
        if (p1_vga) begin m_vga = p1_d; e_vv = 1; end
        else begin m_rdata[p1_o] = p1_d; e_rv[p1_o] = 1; end
      end
      for (int c = 0; c < 5; c++) e_rdata[c*5 +: 5] = m_rdata[c];
      chk("model_rvalid", 64'(rvalid), 64'(e_rv));
      chk("model_rdata", 64'(rdata), 64'(e_rdata));
      chk("model_vga_valid", 64'(vga_valid), 64'(e_vv));
      chk("model_vga_data", 64'(vga_data), 64'(m_vga));

      // who wins this cycle: 5 = VGA, 0..4 = client, -1 = nobody
      any = (req != 5'd0);
      win = -1;
      if (vga_req && !(m_starve >= LIMIT && any)) win = 5;
      else if (any)
        for (int k = 1; k <= 5; k++)
          if (win < 0 && req[(m_rr + k) % 5]) win = (m_rr + k) % 5;
      addr = 0;
      if (win == 5) addr = int'(vga_index);
      else if (win >= 0) addr = int'(index[win*11 +: 11]);
      e_grant = 0;
      if (win >= 0 && win < 5) e_grant[win] = 1;
      e_rd = (win >= 0) && (addr < DEPTH);
      val  = (addr >= DEPTH) ? 5'b11111 : wall_mem[addr];
      chk("model_grant", 64'(grant), 64'(e_grant));
      chk("model_vga_grant", 64'(vga_grant), 64'(win == 5));
      chk("model_mem_addr", 64'(mem_addr), 64'(addr));
      chk("model_mem_rd", 64'(mem_rd), 64'(e_rd));

      if (win == 5 && any) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else if ((win >= 0 && win < 5) || !any) m_starve = 0;
      if (win >= 0 && win < 5) m_rr = win;

      p1_v = p0_v; p1_vga = p0_vga; p1_o = p0_o; p1_d = p0_d;
      p0_v = (win >= 0); p0_vga = (win == 5); p0_o = win; p0_d = val;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [4:0] e5;
  logic       ev;

  initial begin
    for (int i = 0; i < 2048; i++) wall_mem[i] = 5'(i) ^ 5'h0a;
    wall_mem[41] = 5'b10101;
    rst = 1; vga_req = 0; vga_index = 0; req = 0; index = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_grant", 64'(grant), 64'd0);
    tick(); rst = 0;
    @(negedge clk); tick();

    // single pacman lookup at index 41
    req = 5'b00001; index[10:0] = 11'd41;
    @(negedge clk);
    chk("pac_grant", 64'(grant), 64'd1);
    chk("pac_addr", 64'(mem_addr), 64'd41);
    chk("pac_rd", 64'(mem_rd), 64'd1);
    tick(); req = 0;
    @(negedge clk); chk("pac_rvalid_t1", 64'(rvalid), 64'd0);
    tick();
    @(negedge clk);
    chk("pac_rvalid_t2", 64'(rvalid), 64'd1);
    chk("pac_rdata", 64'(rdata[4:0]), 64'(5'b10101));
    tick();

    // reset one cycle after a grant to client 1
    req = 5'b00010; index[21:11] = 11'd300;
    @(negedge clk); chk("rst_pre_grant", 64'(grant), 64'(5'b00010));
    tick(); req = 0; rst = 1;
    @(negedge clk); chk("rst_rvalid", 64'(rvalid), 64'd0);
    tick();
    @(negedge clk); tick();
    rst = 0; req = 5'b00011; index[10:0] = 11'd10; index[21:11] = 11'd11;
    @(negedge clk); chk("rst_first_grant", 64'(grant), 64'(5'b00001));
    tick(); req = 0;
    repeat (3) begin
      @(negedge clk); chk("rst_no_rvalid1", 64'(rvalid[1]), 64'd0);
      tick();
    end

    // round robin with all clients requesting; rr is now 0
    req = 5'b11111;
    for (int c = 0; c < 5; c++) index[c*11 +: 11] = 11'(100 + c);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e5 = 5'b00001 << ((k + 1) % 5);
      chk("rr_grant", 64'(grant), 64'(e5));
      if (k >= 2) begin
        e5 = 5'b00001 << ((k - 1) % 5);
        chk("rr_rvalid", 64'(rvalid), 64'(e5));
      end
      tick();
    end
    req = 0;
    repeat (3) begin @(negedge clk); tick(); end

    // VGA priority and starvation guard
    vga_req = 1; vga_index = 11'd500; req = 5'b00100; index[32:22] = 11'd77;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ev = !(k == 8 || k == 17);
      chk("starve_vga_grant", 64'(vga_grant), 64'(ev));
      chk("starve_grant", 64'(grant), ev ? 64'd0 : 64'(5'b00100));
      tick();
    end
    vga_req = 0; req = 0;
    repeat (3) begin @(negedge clk); tick(); end

    // cancelled client request: VGA wins, ghost 3 drops req
    vga_req = 1; vga_index = 11'd7; req = 5'b10000; index[54:44] = 11'd5;
    @(negedge clk);
    chk("cancel_vga", 64'(vga_grant), 64'd1);
    chk("cancel_grant", 64'(grant), 64'd0);
    tick(); vga_req = 0; req = 0;
    repeat (3) begin
      @(negedge clk); chk("cancel_no_rvalid", 64'(rvalid[4]), 64'd0);
      tick();
    end

    // out-of-range index for ghost 2
    req = 5'b01000; index[43:33] = 11'd1200;
    @(negedge clk);
    chk("oor_grant", 64'(grant), 64'(5'b01000));
    chk("oor_rd", 64'(mem_rd), 64'd0);
    chk("oor_addr", 64'(mem_addr), 64'd1200);
    tick(); req = 0;
    @(negedge clk); tick();
    @(negedge clk);
    chk("oor_rvalid", 64'(rvalid), 64'(5'b01000));
    chk("oor_rdata", 64'(rdata[19:15]), 64'(5'b11111));
    tick();

    // last in-range entry
    req = 5'b01000; index[43:33] = 11'd1199;
    @(negedge clk);
    chk("edge_rd", 64'(mem_rd), 64'd1);
    tick(); req = 0;
    @(negedge clk); tick();
    @(negedge clk);
    chk("edge_rdata", 64'(rdata[19:15]), 64'(5'b00101));
    tick();

    // out-of-range VGA index
    vga_req = 1; vga_index = 11'd2047;
    @(negedge clk); chk("vga_oor_rd", 64'(mem_rd), 64'd0);
    tick(); vga_req = 0;
    @(negedge clk); tick();
    @(negedge clk);
    chk("vga_oor_valid", 64'(vga_valid), 64'd1);
    chk("vga_oor_data", 64'(vga_data), 64'(5'b11111));
    tick();

    repeat (3) begin @(negedge clk); tick(); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
